// File: rtl/twostage_pipelined_subtractor.sv
// -----------------------------------------------------------------------------
// twostage_pipelined_subtractor
//
// Purpose:
//   Two-stage pipelined carry-select subtractor, D = A - B - Bin, with
//   valid/ready streaming at one result per cycle. The difference is formed as
//   A + ~B + ~Bin. The carry chain is split at WIDTH/2.
//   Stage 1 registers the low-half sum and its carry. It also registers both
//   high-half candidates: carry-in 0 and carry-in 1.
//   Stage 2 uses the registered low carry to pick a candidate. It then loads
//   the output register.
//
// Optional feature (macro SUB_SATURATE_EN):
//   When the macro is defined, a signed overflow clamps D to the signed
//   extreme in stage 2. Bout and V are still reported unchanged. When the macro
//   is undefined, D is the wrapped modulo-2^WIDTH result.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand beat present
//   in_ready   out  block accepts a beat this cycle (combinational)
//   A          in   WIDTH-bit minuend
//   B          in   WIDTH-bit subtrahend
//   Bin        in   borrow-in (1 = subtract one more)
//   out_valid  out  result beat present
//   out_ready  in   downstream accepts the result
//   D          out  WIDTH-bit difference, modulo 2^WIDTH
//   Bout       out  borrow-out; 1 iff unsigned A < B + Bin
//   V          out  signed overflow of A - B - Bin
//
// Parameters:
//   WIDTH  operand/result width; must be even and >= 4
// -----------------------------------------------------------------------------
module twostage_pipelined_subtractor #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V
);

    localparam int L = WIDTH / 2;

    // Stage 1 registers
    logic             r_s1_valid;
    logic [L-1:0]     r_dl;
    logic             r_cl;
    logic [L:0]       r_h0;
    logic [L:0]       r_h1;
    logic             r_a_msb;
    logic             r_b_msb;

    // Output registers
    logic             r_out_valid;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_v;

    // Handshake and arithmetic wires
    logic             w_accept;
    logic             w_s1_adv;
    logic [L:0]       w_low_sum;
    logic [L:0]       w_h0;
    logic [L:0]       w_h1;
    logic [L:0]       w_sel_hi;
    logic [WIDTH-1:0] w_d_wrap;
    logic [WIDTH-1:0] w_d_final;
    logic             w_bout;
    logic             w_v;

    // in_ready depends only on the pipeline state and out_ready, never on
    // in_valid. This keeps the upstream handshake free of combinational loops.
    assign w_s1_adv = r_s1_valid && (!r_out_valid || out_ready);
    assign in_ready = !r_s1_valid || w_s1_adv;
    assign w_accept = in_valid && in_ready;

    // Low half: the carry-in is ~Bin. The extra top bit is the carry into the
    // high half.
    assign w_low_sum = {1'b0, A[L-1:0]} + {1'b0, ~B[L-1:0]} + {{L{1'b0}}, ~Bin};

    // The two high-half candidates are computed up front, so stage 1 stores
    // no raw high operand bits.
    assign w_h0 = {1'b0, A[WIDTH-1:L]} + {1'b0, ~B[WIDTH-1:L]};
    assign w_h1 = w_h0 + {{L{1'b0}}, 1'b1};

    // Stage 2 carry select and flag derivation from the registered low carry
    always_comb begin
        w_sel_hi = r_h0;
        if (r_cl) begin
            w_sel_hi = r_h1;
        end else begin
            w_sel_hi = r_h0;
        end
        w_d_wrap = {w_sel_hi[L-1:0], r_dl};
        // A borrow is the absence of a carry out of A + ~B + ~Bin.
        w_bout   = ~w_sel_hi[L];
        w_v      = (r_a_msb != r_b_msb) && (w_d_wrap[WIDTH-1] != r_a_msb);
    end

`ifdef SUB_SATURATE_EN
    // Clamp to the signed extreme on the side of the minuend's sign
    always_comb begin
        w_d_final = w_d_wrap;
        if (w_v && !r_a_msb) begin
            w_d_final = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (w_v && r_a_msb) begin
            w_d_final = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            w_d_final = w_d_wrap;
        end
    end
`else
    assign w_d_final = w_d_wrap;
`endif

    // Stage 1 register: capture the low sum, the candidates and the sign bits on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_dl       <= {L{1'b0}};
            r_cl       <= 1'b0;
            r_h0       <= {(L+1){1'b0}};
            r_h1       <= {(L+1){1'b0}};
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_dl       <= w_low_sum[L-1:0];
                r_cl       <= w_low_sum[L];
                r_h0       <= w_h0;
                r_h1       <= w_h1;
                r_a_msb    <= A[WIDTH-1];
                r_b_msb    <= B[WIDTH-1];
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end else begin
                r_s1_valid <= r_s1_valid;
            end
        end
    end

    // Output register: load on stage-1 advance, drop valid once consumed with nothing behind it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_d         <= {WIDTH{1'b0}};
            r_bout      <= 1'b0;
            r_v         <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_out_valid <= 1'b1;
                r_d         <= w_d_final;
                r_bout      <= w_bout;
                r_v         <= w_v;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign D         = r_d;
    assign Bout      = r_bout;
    assign V         = r_v;

endmodule

// File: tb/tb_twostage_pipelined_subtractor.sv
// -----------------------------------------------------------------------------
// tb_twostage_pipelined_subtractor
//
// Purpose:
//   Directed self-checking bench for twostage_pipelined_subtractor with
//   WIDTH=64. It covers the following:
//     - the reset state
//     - single-beat arithmetic across the split point and at the signed
//       extremes
//     - an asynchronous reset with beats in both stages
//     - streaming under a 1,0,0,1 out_ready pattern
//     - back-to-back throughput
//   Expected values are hand-computed constants or simple closed forms.
//   Inputs are driven 1ns after the rising edge. Outputs are sampled a further
//   1ns later.
// -----------------------------------------------------------------------------
module tb_twostage_pipelined_subtractor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] A;
    logic [63:0] B;
    logic        Bin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] D;
    logic        Bout;
    logic        V;

    int n_tests;
    int n_fail;

    twostage_pipelined_subtractor #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout),
        .V         (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one beat with out_ready held high and check the two-edge latency and the result
    task automatic run_one(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic bin, input logic [63:0] exp_d,
                           input logic exp_bout, input logic exp_v);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        A         = a;
        B         = b;
        Bin       = bin;
        #1;
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, "_lat1"}, {63'd0, out_valid}, 64'd0);
        tick();
        #1;
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_D"}, D, exp_d);
        check({tag, "_Bout"}, {63'd0, Bout}, {63'd0, exp_bout});
        check({tag, "_V"}, {63'd0, V}, {63'd0, exp_v});
        tick();
        check({tag, "_drain"}, {63'd0, out_valid}, 64'd0);
    endtask

    logic [63:0] sat_pos_exp;
    logic [63:0] sat_neg_exp;
    logic [3:0]  rdy_pat;
    bit          mdl_s1;
    bit          mdl_out;
    bit          exp_rdy;
    bit          out_fire;
    bit          s1adv;
    bit          acc;
    int          sent;
    int          recv;
    int          cyc;
    logic [63:0] exp_tp;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = 64'd0;
        B         = 64'd0;
        Bin       = 1'b0;

`ifdef SUB_SATURATE_EN
        sat_pos_exp = 64'h7FFF_FFFF_FFFF_FFFF;
        sat_neg_exp = 64'h8000_0000_0000_0000;
`else
        sat_pos_exp = 64'h8000_0000_0000_0000;
        sat_neg_exp = 64'h7FFF_FFFF_FFFF_FFFF;
`endif

        // Reset state
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_D", D, 64'd0);
        check("rst_Bout", {63'd0, Bout}, 64'd0);
        check("rst_V", {63'd0, V}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst_n = 1'b1;
        tick();

        // Single-beat arithmetic
        run_one("basic", 64'd100, 64'd58, 1'b0, 64'd42, 1'b0, 1'b0);
        run_one("split_borrow", 64'h0000_0001_0000_0000, 64'd1, 1'b0,
                64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0);
        run_one("zero_minus_bin", 64'd0, 64'd0, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        run_one("bin_no_borrow", 64'd5, 64'd3, 1'b1, 64'd1, 1'b0, 1'b0);
        run_one("hi_lo_mix", 64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b0,
                64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0);
        run_one("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                sat_pos_exp, 1'b1, 1'b1);
        run_one("ovf_neg", 64'h8000_0000_0000_0000, 64'd1, 1'b0,
                sat_neg_exp, 1'b0, 1'b1);

        // Mid-stream asynchronous reset with beats in both stages
        out_ready = 1'b0;
        in_valid  = 1'b1;
        A         = 64'd10;
        B         = 64'd1;
        Bin       = 1'b0;
        tick();
        A = 64'd20;
        tick();
        in_valid = 1'b0;
        #1;
        check("mid_pre_valid", {63'd0, out_valid}, 64'd1);
        check("mid_pre_D", D, 64'd9);
        check("mid_pre_in_ready", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_D", D, 64'd0);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mid_no_stale", {63'd0, out_valid}, 64'd0);
        end

        // Streaming with out_ready pattern 1,0,0,1; D = 3i - i = 2i in order
        rdy_pat = 4'b1001;
        mdl_s1  = 1'b0;
        mdl_out = 1'b0;
        sent    = 0;
        recv    = 0;
        cyc     = 0;
        while (recv < 8 && cyc < 100) begin
            out_ready = rdy_pat[cyc % 4];
            in_valid  = (sent < 8);
            A         = 64'(sent * 3);
            B         = 64'(sent);
            Bin       = 1'b0;
            #1;
            exp_rdy = !(mdl_s1 && mdl_out && !out_ready);
            check("strm_in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
            check("strm_out_valid", {63'd0, out_valid}, {63'd0, mdl_out});
            if (mdl_out) begin
                check("strm_D", D, 64'(2 * recv));
            end
            out_fire = mdl_out && out_ready;
            s1adv    = mdl_s1 && (!mdl_out || out_ready);
            acc      = in_valid && exp_rdy;
            @(posedge clk);
            #1;
            mdl_out = s1adv ? 1'b1 : (out_fire ? 1'b0 : mdl_out);
            mdl_s1  = acc ? 1'b1 : (s1adv ? 1'b0 : mdl_s1);
            if (acc) sent++;
            if (out_fire) recv++;
            cyc++;
        end
        in_valid = 1'b0;
        check("strm_all_recv", 64'(recv), 64'd8);
        check("strm_all_sent", 64'(sent), 64'd8);

        // Throughput: 16 back-to-back beats; result k is visible in sample slot k+2
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid = (c < 16);
            A        = 64'(c * 7 + 1000);
            B        = 64'(c);
            Bin      = c[0];
            #1;
            if (c < 16) begin
                check("tp_in_ready", {63'd0, in_ready}, 64'd1);
            end
            if (c >= 2 && c < 18) begin
                exp_tp = 64'((c - 2) * 6 + 1000 - ((c - 2) % 2));
                check("tp_valid", {63'd0, out_valid}, 64'd1);
                check("tp_D", D, exp_tp);
            end else begin
                check("tp_idle", {63'd0, out_valid}, 64'd0);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
